// File: rtl/axi4_default_slave_if.sv
// AXI4 bus interface (axi_inf) carrying all five channels.
// ID, address and data widths are set by the parameters; the slave modport is
// used by terminating slaves such as axi4_default_slave.
interface axi_inf #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Write address channel
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;
    // Write data channel
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // Write response channel
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // Read address channel
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;
    // Read data channel
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_default_slave.sv
// axi4_default_slave: terminating AXI4 slave. Accepts every burst, drains
// write data, answers with a fixed response code and fixed read data.
// One outstanding burst per channel; write and read FSMs run independently.
// Optional transaction counters enabled by defining AXI4_DEFAULT_SLAVE_CNT_EN;
// without it wr_cnt/rd_cnt are tied to zero.
// ID_W and DATA_W must match the connected axi_inf instance.
module axi4_default_slave #(
    parameter string       MODE       = "BOTH",
    parameter logic [1:0]  RESP       = 2'b11,
    parameter logic [63:0] RDATA_FILL = '0,
    parameter int          CNT_W      = 16,
    parameter int          ID_W       = 4,
    parameter int          DATA_W     = 32
) (
    input  logic             clock,
    input  logic             rst,
    axi_inf.slave            inf,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
);
    localparam bit WR_EN = (MODE == "WRITE") || (MODE == "BOTH");
    localparam bit RD_EN = (MODE == "READ")  || (MODE == "BOTH");
    localparam logic [DATA_W-1:0] FILL = DATA_W'(RDATA_FILL);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    logic [1:0]      w_state_q, w_state_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;

    logic            r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [7:0]      rlen_q, rlen_d;
    logic [7:0]      rbeat_q, rbeat_d;

    // Write FSM next state; ready/valid are decoded from the next state so they are registered
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: if (inf.awvalid && awready_q) begin
                bid_d     = inf.awid;
                w_state_d = W_DATA;
            end
            W_DATA: if (inf.wvalid && wready_q && inf.wlast) begin
                w_state_d = W_RESP;
            end
            W_RESP: if (bvalid_q && inf.bready) begin
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = WR_EN && (w_state_d == W_IDLE);
        wready_d  = WR_EN && (w_state_d == W_DATA);
        bvalid_d  = WR_EN && (w_state_d == W_RESP);
    end

    // Read FSM next state; rlast is precomputed from the next beat count
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        case (r_state_q)
            R_IDLE: if (inf.arvalid && arready_q) begin
                rid_d     = inf.arid;
                rlen_d    = inf.arlen;
                rbeat_d   = 8'd0;
                r_state_d = R_DATA;
            end
            R_DATA: if (rvalid_q && inf.rready) begin
                rbeat_d = rbeat_q + 8'd1;
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = RD_EN && (r_state_d == R_IDLE);
        rvalid_d  = RD_EN && (r_state_d == R_DATA);
        rlast_d   = RD_EN && (r_state_d == R_DATA) && (rbeat_d == rlen_d);
    end

    // State and output registers; reset abandons any burst in flight
    always_ff @(posedge clock) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
        end
    end

    assign inf.awready = awready_q;
    assign inf.wready  = wready_q;
    assign inf.bvalid  = bvalid_q;
    assign inf.bid     = bid_q;
    assign inf.bresp   = RESP;
    assign inf.arready = arready_q;
    assign inf.rvalid  = rvalid_q;
    assign inf.rlast   = rlast_q;
    assign inf.rid     = rid_q;
    assign inf.rresp   = RESP;
    assign inf.rdata   = FILL;

`ifdef AXI4_DEFAULT_SLAVE_CNT_EN
    logic             b_done, r_done;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    assign b_done = bvalid_q && inf.bready;
    assign r_done = rvalid_q && rlast_q && inf.rready;

    // Saturating completed-burst counters
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (b_done && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (r_done && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`else
    assign wr_cnt = '0;
    assign rd_cnt = '0;
`endif

    // Address attributes, write data and strobes are intentionally ignored
    logic unused_inputs;
    assign unused_inputs = ^{inf.awaddr, inf.awlen, inf.awsize, inf.awburst, inf.awlock,
                             inf.awcache, inf.awprot, inf.awqos, inf.wdata, inf.wstrb,
                             inf.araddr, inf.arsize, inf.arburst, inf.arlock, inf.arcache,
                             inf.arprot, inf.arqos};
endmodule

// File: tb/tb_axi4_default_slave.sv
// Directed bench for axi4_default_slave: a MODE="BOTH" DECERR instance with a
// truncated fill pattern, and a MODE="READ" OKAY instance.
module tb_axi4_default_slave;
`ifdef AXI4_DEFAULT_SLAVE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam logic [31:0] FILL_EXP = 32'hCAFE_F00D;

    logic        clock;
    logic        rst;
    logic [15:0] wr_cnt0, rd_cnt0, wr_cnt1, rd_cnt1;
    int          tests;
    int          fails;
    int          beats;

    axi_inf #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) a ();
    axi_inf #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) b ();

    axi4_default_slave #(
        .MODE("BOTH"), .RESP(2'b11), .RDATA_FILL(64'hDEAD_BEEF_CAFE_F00D),
        .CNT_W(16), .ID_W(4), .DATA_W(32)
    ) dut (
        .clock(clock), .rst(rst), .inf(a.slave), .wr_cnt(wr_cnt0), .rd_cnt(rd_cnt0)
    );

    axi4_default_slave #(
        .MODE("READ"), .RESP(2'b00), .RDATA_FILL(64'h0),
        .CNT_W(16), .ID_W(4), .DATA_W(32)
    ) dut_rd (
        .clock(clock), .rst(rst), .inf(b.slave), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
        return CNT_ON ? 16'(n) : 16'd0;
    endfunction

    task automatic idle_master_a();
        a.awid = '0; a.awaddr = '0; a.awlen = '0; a.awsize = 3'd2; a.awburst = 2'b01;
        a.awlock = 1'b0; a.awcache = '0; a.awprot = '0; a.awqos = '0; a.awvalid = 1'b0;
        a.wdata = '0; a.wstrb = '1; a.wlast = 1'b0; a.wvalid = 1'b0; a.bready = 1'b0;
        a.arid = '0; a.araddr = '0; a.arlen = '0; a.arsize = 3'd2; a.arburst = 2'b01;
        a.arlock = 1'b0; a.arcache = '0; a.arprot = '0; a.arqos = '0; a.arvalid = 1'b0;
        a.rready = 1'b0;
    endtask

    task automatic idle_master_b();
        b.awid = '0; b.awaddr = '0; b.awlen = '0; b.awsize = 3'd2; b.awburst = 2'b01;
        b.awlock = 1'b0; b.awcache = '0; b.awprot = '0; b.awqos = '0; b.awvalid = 1'b0;
        b.wdata = '0; b.wstrb = '1; b.wlast = 1'b0; b.wvalid = 1'b0; b.bready = 1'b0;
        b.arid = '0; b.araddr = '0; b.arlen = '0; b.arsize = 3'd2; b.arburst = 2'b01;
        b.arlock = 1'b0; b.arcache = '0; b.arprot = '0; b.arqos = '0; b.arvalid = 1'b0;
        b.rready = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        idle_master_a();
        idle_master_b();
        tick();
        tick();

        // Reset state
        check("rst_awready", a.awready, 0);
        check("rst_arready", a.arready, 0);
        check("rst_wready", a.wready, 0);
        check("rst_bvalid", a.bvalid, 0);
        check("rst_rvalid", a.rvalid, 0);
        check("rst_rlast", a.rlast, 0);
        check("rst_bid", a.bid, 0);
        check("rst_rid", a.rid, 0);
        check("rst_wr_cnt", wr_cnt0, 0);
        check("rst_rd_cnt", rd_cnt0, 0);
        rst = 1'b0;
        tick();
        check("post_rst_awready", a.awready, 1);
        check("post_rst_arready", a.arready, 1);

        // Write burst: W presented before AW stalls, then AW id=3 len=3 and 4 beats
        a.wvalid = 1'b1;
        a.wdata  = 32'h1111_0000;
        tick();
        check("w_before_aw_wready", a.wready, 0);
        a.awvalid = 1'b1; a.awid = 4'd3; a.awlen = 8'd3;
        tick();
        a.awvalid = 1'b0;
        check("aw_hs_awready", a.awready, 0);
        check("aw_hs_wready", a.wready, 1);
        for (int i = 0; i < 4; i++) begin
            a.wdata = 32'h1111_0000 + 32'(i);
            a.wlast = (i == 3);
            check("w_beat_wready", a.wready, 1);
            check("w_beat_bvalid", a.bvalid, 0);
            tick();
        end
        a.wvalid = 1'b0;
        a.wlast  = 1'b0;
        check("b_bvalid", a.bvalid, 1);
        check("b_bid", a.bid, 3);
        check("b_bresp", a.bresp, 2'b11);
        check("b_wready_low", a.wready, 0);
        check("b_awready_low", a.awready, 0);
        a.bready = 1'b1;
        tick();
        a.bready = 1'b0;
        check("b_done_bvalid", a.bvalid, 0);
        check("b_done_awready", a.awready, 1);
        check("wr_cnt_1", wr_cnt0, cnt_exp(1));

        // Read burst: AR id=5 len=7, rready held high
        a.arvalid = 1'b1; a.arid = 4'd5; a.arlen = 8'd7; a.rready = 1'b1;
        tick();
        a.arvalid = 1'b0;
        check("ar_hs_arready", a.arready, 0);
        for (int i = 0; i < 8; i++) begin
            check("r8_rvalid", a.rvalid, 1);
            check("r8_rid", a.rid, 5);
            check("r8_rdata", a.rdata, FILL_EXP);
            check("r8_rresp", a.rresp, 2'b11);
            check("r8_rlast", a.rlast, (i == 7));
            tick();
        end
        check("r8_done_rvalid", a.rvalid, 0);
        check("r8_done_arready", a.arready, 1);
        check("rd_cnt_1", rd_cnt0, cnt_exp(1));

        // 256-beat read with rready toggling every other cycle
        a.arvalid = 1'b1; a.arid = 4'd9; a.arlen = 8'd255; a.rready = 1'b0;
        tick();
        a.arvalid = 1'b0;
        beats = 0;
        for (int c = 0; c < 600 && beats < 256; c++) begin
            a.rready = c[0];
            check("r256_rvalid", a.rvalid, 1);
            check("r256_rid", a.rid, 9);
            check("r256_rdata", a.rdata, FILL_EXP);
            check("r256_rlast", a.rlast, (beats == 255));
            if (a.rready) beats++;
            tick();
        end
        a.rready = 1'b1;
        check("r256_done_rvalid", a.rvalid, 0);
        check("r256_done_arready", a.arready, 1);
        check("rd_cnt_2", rd_cnt0, cnt_exp(2));

        // Concurrent single-beat write and read, B held off for 5 cycles
        a.awvalid = 1'b1; a.awid = 4'd6; a.awlen = 8'd0;
        a.arvalid = 1'b1; a.arid = 4'd2; a.arlen = 8'd0;
        tick();
        a.awvalid = 1'b0;
        a.arvalid = 1'b0;
        check("cc_wready", a.wready, 1);
        check("cc_rvalid", a.rvalid, 1);
        check("cc_rlast", a.rlast, 1);
        check("cc_rid", a.rid, 2);
        a.wvalid = 1'b1; a.wlast = 1'b1;
        tick();
        a.wvalid = 1'b0; a.wlast = 1'b0;
        check("cc_r_done_rvalid", a.rvalid, 0);
        check("cc_r_done_arready", a.arready, 1);
        for (int i = 0; i < 5; i++) begin
            check("cc_bvalid_hold", a.bvalid, 1);
            check("cc_bid_hold", a.bid, 6);
            check("cc_awready_low", a.awready, 0);
            tick();
        end
        a.bready = 1'b1;
        check("cc_bvalid_pre_hs", a.bvalid, 1);
        tick();
        a.bready = 1'b0;
        check("cc_bvalid_done", a.bvalid, 0);
        check("cc_awready_back", a.awready, 1);
        check("wr_cnt_2", wr_cnt0, cnt_exp(2));
        check("rd_cnt_3", rd_cnt0, cnt_exp(3));

        // Reset pulsed while beat 3 of an 8-beat read is on the bus
        a.arvalid = 1'b1; a.arid = 4'd1; a.arlen = 8'd7; a.rready = 1'b1;
        tick();
        a.arvalid = 1'b0;
        tick();
        tick();
        check("rr_beat3_rvalid", a.rvalid, 1);
        check("rr_beat3_rlast", a.rlast, 0);
        rst = 1'b1;
        tick();
        check("rr_rvalid_drop", a.rvalid, 0);
        check("rr_rlast_drop", a.rlast, 0);
        check("rr_wr_cnt", wr_cnt0, 0);
        check("rr_rd_cnt", rd_cnt0, 0);
        rst = 1'b0;
        tick();
        check("rr_arready_back", a.arready, 1);
        check("rr_rvalid_idle", a.rvalid, 0);
        a.rready = 1'b0;

        // MODE="READ": write channel tied off while AW/W are offered
        b.awvalid = 1'b1; b.awid = 4'd7; b.wvalid = 1'b1; b.wlast = 1'b1; b.bready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("ro_awready", b.awready, 0);
            check("ro_wready", b.wready, 0);
            check("ro_bvalid", b.bvalid, 0);
            tick();
        end
        check("ro_wr_cnt", wr_cnt1, 0);
        b.arvalid = 1'b1; b.arid = 4'd4; b.arlen = 8'd1; b.rready = 1'b1;
        check("ro_arready", b.arready, 1);
        tick();
        b.arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ro_rvalid", b.rvalid, 1);
            check("ro_rid", b.rid, 4);
            check("ro_rdata", b.rdata, 0);
            check("ro_rresp", b.rresp, 2'b00);
            check("ro_rlast", b.rlast, (i == 1));
            tick();
        end
        check("ro_done_rvalid", b.rvalid, 0);
        check("ro_rd_cnt", rd_cnt1, cnt_exp(1));
        idle_master_b();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
